// File: rtl/apple_ctl_if.sv
// Occupancy query handshake between the apple placer and the snake body logic.
//   occ_req : query request, held with occ_x/occ_y until answered
//   occ_x   : queried column (7 bits)
//   occ_y   : queried row (6 bits)
//   occ_ack : query answered this cycle
//   occ_hit : queried cell is occupied (meaningful only with occ_ack)
// master: the apple placer; slave: the occupancy responder.
interface apple_ctl_if;
    logic       occ_req;
    logic [6:0] occ_x;
    logic [5:0] occ_y;
    logic       occ_ack;
    logic       occ_hit;

    modport master (output occ_req, occ_x, occ_y, input occ_ack, occ_hit);
    modport slave  (input occ_req, occ_x, occ_y, output occ_ack, occ_hit);
endinterface

// File: rtl/apple_ctl.sv
// Apple placement controller for the snake game.
// Draws pseudo-random candidate cells from a 16-bit LFSR, asks the snake body
// logic whether each in-range candidate is free, and publishes the chosen cell
// only at a frame boundary so the drawn apple never moves mid-frame.
// Ports:
//   pclk, rst        : clock and synchronous active-high reset
//   game_start       : pulse, start (or restart) a game
//   eaten            : pulse, snake head reached the apple
//   frame_tick       : pulse, start of vertical blanking (commit point)
//   occ              : occupancy query handshake (master side)
//   apple_x, apple_y : registered apple cell
//   apple_valid      : apple is displayed
//   busy             : placement in progress (GEN, REQ, COMMIT)
//   place_fail       : one-cycle pulse when the try limit is exhausted
//   apple_cnt        : apples eaten since game_start, saturating at 255
module apple_ctl #(
    parameter int          GRID_W    = 40,
    parameter int          GRID_H    = 30,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [7:0]  MAX_TRIES = 8'd64
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        game_start,
    input  logic        eaten,
    input  logic        frame_tick,
    apple_ctl_if.master occ,
    output logic [6:0]  apple_x,
    output logic [5:0]  apple_y,
    output logic        apple_valid,
    output logic        busy,
    output logic        place_fail,
    output logic [7:0]  apple_cnt
);

    typedef enum logic [2:0] {IDLE, GEN, REQ, COMMIT, PLACED} state_t;

    localparam logic [7:0] GRID_W_L = 8'(GRID_W);
    localparam logic [6:0] GRID_H_L = 7'(GRID_H);

    state_t      state;
    logic [15:0] lfsr;
    logic [7:0]  try_cnt;
    logic        restart_pend;
    logic [6:0]  pend_x;
    logic [5:0]  pend_y;

    logic [6:0]  cx;
    logic [5:0]  cy;
    logic        in_range;
    logic        lfsr_fb;

    assign cx       = lfsr[6:0];
    assign cy       = lfsr[13:8];
    assign in_range = ({1'b0, cx} < GRID_W_L) && ({1'b0, cy} < GRID_H_L);
    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge pclk) begin
        if (rst) begin
            state        <= IDLE;
            lfsr         <= LFSR_SEED;
            try_cnt      <= 8'd0;
            restart_pend <= 1'b0;
            apple_x      <= 7'd0;
            apple_y      <= 6'd0;
            apple_valid  <= 1'b0;
            busy         <= 1'b0;
            place_fail   <= 1'b0;
            apple_cnt    <= 8'd0;
            occ.occ_req  <= 1'b0;
            occ.occ_x    <= 7'd0;
            occ.occ_y    <= 6'd0;
        end else begin
            place_fail <= 1'b0;

            // The LFSR only steps while a candidate is being drawn, so the
            // candidate sequence depends on placement history alone.
            if (state == GEN)
                lfsr <= {lfsr[14:0], lfsr_fb};

            // Outside REQ a start restarts immediately; inside REQ the
            // outstanding query must finish first, so it is only remembered.
            if (game_start && state != REQ) begin
                try_cnt     <= 8'd0;
                apple_cnt   <= 8'd0;
                apple_valid <= 1'b0;
                busy        <= 1'b1;
                state       <= GEN;
            end else begin
                case (state)
                    IDLE: ;
                    GEN: begin
                        // Out-of-range candidates are dropped without a query.
                        if (in_range) begin
                            occ.occ_x   <= cx;
                            occ.occ_y   <= cy;
                            occ.occ_req <= 1'b1;
                            try_cnt     <= try_cnt + 8'd1;
                            state       <= REQ;
                        end
                    end
                    REQ: begin
                        if (occ.occ_ack) begin
                            occ.occ_req <= 1'b0;
                            if (restart_pend || game_start) begin
                                // Answer is stale once a restart is pending.
                                restart_pend <= 1'b0;
                                try_cnt      <= 8'd0;
                                apple_cnt    <= 8'd0;
                                apple_valid  <= 1'b0;
                                state        <= GEN;
                            end else if (!occ.occ_hit) begin
                                pend_x <= occ.occ_x;
                                pend_y <= occ.occ_y;
                                state  <= COMMIT;
                            end else if (try_cnt < MAX_TRIES) begin
                                state <= GEN;
                            end else begin
                                place_fail  <= 1'b1;
                                apple_valid <= 1'b0;
                                busy        <= 1'b0;
                                state       <= IDLE;
                            end
                        end else if (game_start) begin
                            restart_pend <= 1'b1;
                        end
                    end
                    COMMIT: begin
                        if (frame_tick) begin
                            apple_x     <= pend_x;
                            apple_y     <= pend_y;
                            apple_valid <= 1'b1;
                            busy        <= 1'b0;
                            state       <= PLACED;
                        end
                    end
                    PLACED: begin
                        // eaten wins over a coincident frame_tick.
                        if (eaten) begin
                            apple_valid <= 1'b0;
                            apple_cnt   <= sat_inc(apple_cnt);
                            try_cnt     <= 8'd0;
                            busy        <= 1'b1;
                            state       <= GEN;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
